// File: rtl/shift_pattern_checker_if.sv
// Sample bus between a rotating shifter and shift_pattern_checker.
// The master drives the samples and the slave (the checker) returns its lock and error status.
interface shift_pattern_checker_if #(
    parameter int BIT_WIDTH = 8,
    parameter int ERR_W     = 16
);
    logic [BIT_WIDTH-1:0] q_in;
    logic                 in_valid;
    logic                 locked;
    logic                 err_pulse;
    logic [ERR_W-1:0]     err_cnt;
    logic [BIT_WIDTH-1:0] expected;
    logic                 dir;

    modport master (
        output q_in, in_valid,
        input  locked, err_pulse, err_cnt, expected, dir
    );

    modport slave (
        input  q_in, in_valid,
        output locked, err_pulse, err_cnt, expected, dir
    );
endinterface

// File: rtl/shift_pattern_checker.sv
// Locks onto a rotating shifter pattern, flywheels the expected value and counts deviations.
// Define BIDIR_DETECT_EN to also detect right rotation; otherwise only left rotation locks.
//
// state    | meaning
// S_IDLE   | no reference sample captured yet
// S_HUNT   | counting consecutive rotation matches toward lock
// S_LOCKED | flywheeling expected value, flagging mismatches
module shift_pattern_checker #(
    parameter int BIT_WIDTH = 8,
    parameter int LOCK_CNT  = 4,
    parameter int LOSS_CNT  = 2,
    parameter int ERR_W     = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    shift_pattern_checker_if.slave  bus
);
    localparam int MC_W = $clog2(LOCK_CNT + 1);
    localparam int MS_W = $clog2(LOSS_CNT + 1);
    localparam logic [MC_W-1:0] MC_LAST = MC_W'(LOCK_CNT - 1);
    localparam logic [MS_W-1:0] MS_LAST = MS_W'(LOSS_CNT - 1);

    typedef enum logic [1:0] {S_IDLE, S_HUNT, S_LOCKED} state_e;

    function automatic logic [BIT_WIDTH-1:0] rotl(input logic [BIT_WIDTH-1:0] x);
        return {x[BIT_WIDTH-2:0], x[BIT_WIDTH-1]};
    endfunction

    state_e               state_q, state_d;
    logic [BIT_WIDTH-1:0] prev_q, prev_d;
    logic [MC_W-1:0]      match_l_q, match_l_d;
    logic [MS_W-1:0]      miss_q, miss_d;
    logic [ERR_W-1:0]     err_cnt_q, err_cnt_d;
    logic                 locked_q, locked_d;
    logic                 err_pulse_q, err_pulse_d;
    logic [BIT_WIDTH-1:0] expected_w;
    logic                 degen_w;
    logic                 hit_l_w;
    logic                 hit_exp_w;
    logic                 lock_go;

`ifdef BIDIR_DETECT_EN
    function automatic logic [BIT_WIDTH-1:0] rotr(input logic [BIT_WIDTH-1:0] x);
        return {x[0], x[BIT_WIDTH-1:1]};
    endfunction

    logic [MC_W-1:0] match_r_q, match_r_d;
    logic            dir_q, dir_d;
    logic            hit_r_w;

    assign expected_w = dir_q ? rotr(prev_q) : rotl(prev_q);
    assign hit_r_w    = !degen_w && (bus.q_in == rotr(prev_q));
    assign bus.dir    = dir_q;
`else
    assign expected_w = rotl(prev_q);
    assign bus.dir    = 1'b0;
`endif

    // All-zeros and all-ones survive any rotation, so they can never prove lock.
    assign degen_w   = (bus.q_in == '0) || (bus.q_in == '1);
    assign hit_l_w   = !degen_w && (bus.q_in == rotl(prev_q));
    assign hit_exp_w = !degen_w && (bus.q_in == expected_w);

    always_comb begin
        state_d     = state_q;
        prev_d      = prev_q;
        match_l_d   = match_l_q;
        miss_d      = miss_q;
        err_cnt_d   = err_cnt_q;
        locked_d    = locked_q;
        err_pulse_d = 1'b0;
        lock_go     = 1'b0;
`ifdef BIDIR_DETECT_EN
        match_r_d   = match_r_q;
        dir_d       = dir_q;
`endif
        if (bus.in_valid) begin
            case (state_q)
                S_IDLE: begin
                    prev_d    = bus.q_in;
                    match_l_d = '0;
`ifdef BIDIR_DETECT_EN
                    match_r_d = '0;
`endif
                    state_d   = S_HUNT;
                end
                S_HUNT: begin
                    prev_d    = bus.q_in;
                    match_l_d = hit_l_w ? match_l_q + 1'b1 : '0;
`ifdef BIDIR_DETECT_EN
                    match_r_d = hit_r_w ? match_r_q + 1'b1 : '0;
                    // Left is checked first so it wins a same-cycle tie.
                    if (hit_l_w && (match_l_q == MC_LAST)) begin
                        lock_go = 1'b1;
                        dir_d   = 1'b0;
                    end else if (hit_r_w && (match_r_q == MC_LAST)) begin
                        lock_go = 1'b1;
                        dir_d   = 1'b1;
                    end
`else
                    lock_go = hit_l_w && (match_l_q == MC_LAST);
`endif
                    if (lock_go) begin
                        state_d   = S_LOCKED;
                        locked_d  = 1'b1;
                        miss_d    = '0;
                        match_l_d = '0;
`ifdef BIDIR_DETECT_EN
                        match_r_d = '0;
`endif
                    end
                end
                S_LOCKED: begin
                    if (hit_exp_w) begin
                        prev_d = bus.q_in;
                        miss_d = '0;
                    end else begin
                        err_pulse_d = 1'b1;
                        if (err_cnt_q != '1) begin
                            err_cnt_d = err_cnt_q + 1'b1;
                        end
                        if (miss_q == MS_LAST) begin
                            state_d   = S_HUNT;
                            locked_d  = 1'b0;
                            match_l_d = '0;
                            miss_d    = '0;
                            prev_d    = bus.q_in;
`ifdef BIDIR_DETECT_EN
                            match_r_d = '0;
                            dir_d     = 1'b0;
`endif
                        end else begin
                            // Flywheel past the glitch so the next good sample still matches.
                            prev_d = expected_w;
                            miss_d = miss_q + 1'b1;
                        end
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            prev_q      <= '0;
            match_l_q   <= '0;
            miss_q      <= '0;
            err_cnt_q   <= '0;
            locked_q    <= 1'b0;
            err_pulse_q <= 1'b0;
`ifdef BIDIR_DETECT_EN
            match_r_q   <= '0;
            dir_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            prev_q      <= prev_d;
            match_l_q   <= match_l_d;
            miss_q      <= miss_d;
            err_cnt_q   <= err_cnt_d;
            locked_q    <= locked_d;
            err_pulse_q <= err_pulse_d;
`ifdef BIDIR_DETECT_EN
            match_r_q   <= match_r_d;
            dir_q       <= dir_d;
`endif
        end
    end

    assign bus.locked    = locked_q;
    assign bus.err_pulse = err_pulse_q;
    assign bus.err_cnt   = err_cnt_q;
    assign bus.expected  = expected_w;
endmodule
